mem_mfc_ctrl: RTL and testbench

- Data-memory stage that sits directly upstream of the microprogrammed control unit and supplies its `mfc` input.
- Accepts a memory request (MOV, RW, DT, ADDR, DIN) from the control signals the ROM emits.
- Performs a byte, halfword or word access to a big-endian byte-addressed RAM after a programmable number of wait states.
- Signals completion with MFC using a four-phase MOV/MFC handshake.

---
 rtl/mem_mfc_ctrl_pkg.sv | 35 +++
 rtl/mem_mfc_ctrl_byte_array.sv | 44 ++++
 rtl/mem_mfc_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_mem_mfc_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_mfc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-memory stage in front of the microprogrammed
// control unit: FSM state encodings, data-type codes, counter width and the
// request alignment check.
// -----------------------------------------------------------------------------
package mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic [1:0] DT_BYTE = 2'b00;
   localparam logic [1:0] DT_HALF = 2'b01;
   localparam logic [1:0] DT_WORD = 2'b10;

   // Wait-state counter width; covers WAIT_CYC in 0..15.
   localparam int CNT_W = 4;

   // Returns 1 when a request must be rejected: reserved data type, or a
   // halfword/word whose address is not a multiple of its size.
   function automatic logic align_bad(input logic [1:0] dt, input logic [1:0] addr_lo);
      logic bad;
      case (dt)
         DT_BYTE: bad = 1'b0;
         DT_HALF: bad = addr_lo[0];
         DT_WORD: bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_mfc_ctrl_byte_array.sv
// -----------------------------------------------------------------------------
// mem_byte_array
// Byte-addressed storage of 2^ADDR_W bytes viewed through four byte lanes.
// Lane k addresses byte i_base+k; lane 0 is the most significant byte of the
// 32-bit bus (big-endian). Writes are synchronous, reads are combinational.
// Contents have no reset.
//   i_clk    : clock
//   i_base   : base byte address of lane 0
//   i_we     : per-lane write enables, i_we[3] = lane 0 ... i_we[0] = lane 3
//   i_wdata  : write data, lane 0 in [31:24]
//   o_rdata  : read data,  lane 0 in [31:24]
// -----------------------------------------------------------------------------
module mem_byte_array #(
   parameter int ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic [ADDR_W-1:0] i_base,
   input  logic [3:0]        i_we,
   input  logic [31:0]       i_wdata,
   output logic [31:0]       o_rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [7:0] r_mem [0:DEPTH-1];

   // Lane writes on the access edge; only the enabled lanes change.
   always_ff @(posedge i_clk) begin
      for (int k = 0; k < 4; k++) begin
         if (i_we[3-k]) begin
            r_mem[i_base + ADDR_W'(k)] <= i_wdata[31-8*k -: 8];
         end
      end
   end

   // Combinational gather of the four lanes starting at the base address.
   always_comb begin
      o_rdata = 32'h0000_0000;
      for (int k = 0; k < 4; k++) begin
         o_rdata[31-8*k -: 8] = r_mem[i_base + ADDR_W'(k)];
      end
   end

endmodule

// File: rtl/mem_mfc_ctrl.sv
// -----------------------------------------------------------------------------
// mem_mfc_ctrl
// Data-memory stage feeding the control unit's mfc input. Accepts a request
// when MOV is seen in IDLE, waits WAIT_CYC cycles, performs a big-endian byte,
// halfword or word access, then raises MFC until MOV is released
// (four-phase MOV/MFC handshake). Misaligned or reserved requests complete
// immediately with ALIGN_ERR.
//   CLK       : clock, rising edge
//   CLR       : asynchronous active-low reset (RAM contents survive)
//   MOV       : request valid, held until MFC is seen
//   RW        : 1 = read, 0 = write
//   DT        : 00 byte, 01 halfword, 10 word, 11 reserved
//   ADDR      : byte address
//   DIN       : write data, right-justified
//   DOUT      : read data, right-justified, zero-extended (registered)
//   MFC       : memory function complete (registered)
//   ALIGN_ERR : request rejected, valid while MFC=1 (registered)
// -----------------------------------------------------------------------------
module mem_mfc_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int WAIT_CYC = 2
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              MOV,
   input  logic              RW,
   input  logic [1:0]        DT,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [31:0]       DIN,
   output logic [31:0]       DOUT,
   output logic              MFC,
   output logic              ALIGN_ERR
);

   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYC);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_mfc;
   logic              r_align_err;
   logic [31:0]       r_dout;

   logic              r_rw;
   logic [1:0]        r_dt;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_din;

   state_t            w_state_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_mfc_nxt;
   logic              w_err_nxt;
   logic [31:0]       w_dout_nxt;
   logic              w_latch;
   logic              w_access;

   logic [3:0]        w_lanes;
   logic [3:0]        w_we;
   logic [31:0]       w_wdata;
   logic [31:0]       w_rdata;
   logic [31:0]       w_rd_fmt;

   mem_byte_array #(
      .ADDR_W (ADDR_W)
   ) u_mem (
      .i_clk   (CLK),
      .i_base  (r_addr),
      .i_we    (w_we),
      .i_wdata (w_wdata),
      .o_rdata (w_rdata)
   );

   // Map the latched data type onto byte lanes: data is right-justified on
   // DIN/DOUT but the array puts byte A on the top lane.
   always_comb begin
      w_lanes  = 4'b0000;
      w_wdata  = 32'h0000_0000;
      w_rd_fmt = 32'h0000_0000;
      case (r_dt)
         DT_BYTE: begin
            w_lanes  = 4'b1000;
            w_wdata  = {r_din[7:0], 24'h00_0000};
            w_rd_fmt = {24'h00_0000, w_rdata[31:24]};
         end
         DT_HALF: begin
            w_lanes  = 4'b1100;
            w_wdata  = {r_din[15:0], 16'h0000};
            w_rd_fmt = {16'h0000, w_rdata[31:16]};
         end
         DT_WORD: begin
            w_lanes  = 4'b1111;
            w_wdata  = r_din;
            w_rd_fmt = w_rdata;
         end
         default: begin
            w_lanes  = 4'b0000;
            w_wdata  = 32'h0000_0000;
            w_rd_fmt = 32'h0000_0000;
         end
      endcase
   end

   assign w_we = (w_access && !r_rw) ? w_lanes : 4'b0000;

   // Next-state and next-output logic for the handshake FSM.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_mfc_nxt   = r_mfc;
      w_err_nxt   = r_align_err;
      w_dout_nxt  = r_dout;
      w_latch     = 1'b0;
      w_access    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_mfc_nxt = 1'b0;
            w_err_nxt = 1'b0;
            if (MOV) begin
               w_latch = 1'b1;
               if (align_bad(DT, ADDR[1:0])) begin
                  // Rejected requests skip the wait and never touch the RAM.
                  w_state_nxt = ST_DONE;
                  w_mfc_nxt   = 1'b1;
                  w_err_nxt   = 1'b1;
                  w_dout_nxt  = 32'h0000_0000;
               end else begin
                  w_state_nxt = ST_WAIT;
                  w_cnt_nxt   = WAIT_INIT;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!MOV) begin
               // Control unit withdrew the request before the access edge.
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = {CNT_W{1'b0}};
            end else if (r_cnt != {CNT_W{1'b0}}) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
               w_access    = 1'b1;
               w_state_nxt = ST_DONE;
               w_mfc_nxt   = 1'b1;
               if (r_rw) begin
                  w_dout_nxt = w_rd_fmt;
               end else begin
                  w_dout_nxt = r_dout;
               end
            end
         end
         ST_DONE: begin
            if (!MOV) begin
               w_state_nxt = ST_IDLE;
               w_mfc_nxt   = 1'b0;
               w_err_nxt   = 1'b0;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_mfc_nxt   = 1'b0;
            w_err_nxt   = 1'b0;
         end
      endcase
   end

   // State register and registered handshake outputs.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_state     <= ST_IDLE;
         r_cnt       <= {CNT_W{1'b0}};
         r_mfc       <= 1'b0;
         r_align_err <= 1'b0;
         r_dout      <= 32'h0000_0000;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_mfc       <= w_mfc_nxt;
         r_align_err <= w_err_nxt;
         r_dout      <= w_dout_nxt;
      end
   end

   // Request capture at accept; inputs are ignored until the next accept.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_rw   <= 1'b0;
         r_dt   <= 2'b00;
         r_addr <= {ADDR_W{1'b0}};
         r_din  <= 32'h0000_0000;
      end else if (w_latch) begin
         r_rw   <= RW;
         r_dt   <= DT;
         r_addr <= ADDR;
         r_din  <= DIN;
      end else begin
         r_rw   <= r_rw;
         r_dt   <= r_dt;
         r_addr <= r_addr;
         r_din  <= r_din;
      end
   end

   assign DOUT      = r_dout;
   assign MFC       = r_mfc;
   assign ALIGN_ERR = r_align_err;

endmodule

// File: tb/tb_mem_mfc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_mfc_ctrl
// Bench for mem_mfc_ctrl. Two instances share stimulus: one with WAIT_CYC=2,
// one with WAIT_CYC=0; sel0 routes MOV and observation to the second.
// Expected responses come from a byte-array reference model and are queued
// when a request is driven, then popped when MFC rises.
// -----------------------------------------------------------------------------
module tb_mem_mfc_ctrl;

   logic        clk = 1'b0;
   logic        clr_n = 1'b1;
   logic        mov = 1'b0;
   logic        rw = 1'b1;
   logic [1:0]  dt = 2'b00;
   logic [7:0]  addr = 8'h00;
   logic [31:0] din = 32'h0;
   logic        sel0 = 1'b0;

   logic        mov2, mov0;
   logic [31:0] dout2, dout0, w_dout;
   logic        mfc2, mfc0, err2, err0, w_mfc, w_err;

   always #5 clk = ~clk;

   assign mov2   = mov & ~sel0;
   assign mov0   = mov & sel0;
   assign w_dout = sel0 ? dout0 : dout2;
   assign w_mfc  = sel0 ? mfc0 : mfc2;
   assign w_err  = sel0 ? err0 : err2;

   mem_mfc_ctrl #(.ADDR_W(8), .WAIT_CYC(2)) dut (
      .CLK(clk), .CLR(clr_n), .MOV(mov2), .RW(rw), .DT(dt), .ADDR(addr),
      .DIN(din), .DOUT(dout2), .MFC(mfc2), .ALIGN_ERR(err2));

   mem_mfc_ctrl #(.ADDR_W(8), .WAIT_CYC(0)) dut0 (
      .CLK(clk), .CLR(clr_n), .MOV(mov0), .RW(rw), .DT(dt), .ADDR(addr),
      .DIN(din), .DOUT(dout0), .MFC(mfc0), .ALIGN_ERR(err0));

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0]  m2 [256];
   logic [7:0]  m0 [256];
   logic [31:0] last2 = 32'h0;
   logic [31:0] last0 = 32'h0;

   typedef struct {
      logic [31:0] dout;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb[$];

   function automatic logic [7:0] mrd(input int a);
      return sel0 ? m0[a] : m2[a];
   endfunction

   task automatic mwr(input int a, input logic [7:0] b);
      if (sel0) m0[a] = b;
      else      m2[a] = b;
   endtask

   function automatic logic [31:0] model_read(input logic [1:0] d, input int a);
      case (d)
         2'd0:    return {24'h0, mrd(a)};
         2'd1:    return {16'h0, mrd(a), mrd(a+1)};
         2'd2:    return {mrd(a), mrd(a+1), mrd(a+2), mrd(a+3)};
         default: return 32'h0;
      endcase
   endfunction

   // One complete request/handshake; hold = extra cycles MOV stays high after MFC.
   task automatic do_req(input logic r, input logic [1:0] d, input logic [7:0] a,
                         input logic [31:0] wd, input int hold, input string nm);
      exp_t e;
      logic bad;
      logic seen;
      int   k;
      int   wc;
      wc  = sel0 ? 0 : 2;
      bad = (d == 2'd3) || (d == 2'd1 && a[0]) || (d == 2'd2 && a[1:0] != 2'b00);
      if (bad) begin
         e.dout = 32'h0; e.err = 1'b1; e.lat = 0;
      end else begin
         e.err = 1'b0; e.lat = wc + 1;
         e.dout = r ? model_read(d, int'(a)) : (sel0 ? last0 : last2);
      end
      sb.push_back(e);
      mov = 1'b1; rw = r; dt = d; addr = a; din = wd;
      seen = 1'b0; k = -1;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            rw = ~r; dt = 2'($urandom_range(0, 3)); addr = 8'($urandom); din = $urandom;
         end
         if (w_mfc) begin
            seen = 1'b1; k = i;
         end
      end
      n_checks++;
      if (!seen) begin
         $display("FAIL %s timeout: MFC never rose within 30 edges", nm);
         void'(sb.pop_front());
         mov = 1'b0;
         repeat (3) @(posedge clk);
         #1;
      end else begin
         e = sb.pop_front();
         if (k !== e.lat) $display("FAIL %s latency: got E0+%0d want E0+%0d", nm, k, e.lat);
         else n_pass++;
         n_checks++;
         if (w_dout !== e.dout) $display("FAIL %s dout: got %h want %h", nm, w_dout, e.dout);
         else n_pass++;
         n_checks++;
         if (w_err !== e.err) $display("FAIL %s align_err: got %b want %b", nm, w_err, e.err);
         else n_pass++;
         if (!bad && !r) begin
            case (d)
               2'd0: mwr(int'(a), wd[7:0]);
               2'd1: begin mwr(int'(a), wd[15:8]); mwr(int'(a)+1, wd[7:0]); end
               default: begin
                  mwr(int'(a), wd[31:24]); mwr(int'(a)+1, wd[23:16]);
                  mwr(int'(a)+2, wd[15:8]); mwr(int'(a)+3, wd[7:0]);
               end
            endcase
         end
         if (sel0) last0 = e.dout;
         else      last2 = e.dout;
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            n_checks++;
            if (w_mfc !== 1'b1 || w_dout !== e.dout)
               $display("FAIL %s hold%0d: got mfc=%b dout=%h want mfc=1 dout=%h", nm, h, w_mfc, w_dout, e.dout);
            else n_pass++;
         end
         mov = 1'b0;
         @(posedge clk); #1;
         n_checks++;
         if (w_mfc !== 1'b0 || w_err !== 1'b0 || w_dout !== e.dout)
            $display("FAIL %s release: got mfc=%b err=%b dout=%h want mfc=0 err=0 dout=%h",
                     nm, w_mfc, w_err, w_dout, e.dout);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      #2 clr_n = 1'b0;
      #3;
      n_checks++;
      if (dout2 !== 32'h0 || mfc2 !== 1'b0 || err2 !== 1'b0)
         $display("FAIL reset_state: got dout=%h mfc=%b err=%b want 0/0/0", dout2, mfc2, err2);
      else n_pass++;
      @(posedge clk); #1 clr_n = 1'b1;
      do_req(1'b0, 2'd2, 8'h10, 32'h0BADF00D, 0, "rst_pre_wr");
      do_req(1'b1, 2'd2, 8'h10, 32'h0, 0, "rst_pre_rd");
      // Start a write, then reset while the wait counter is running.
      mov = 1'b1; rw = 1'b0; dt = 2'd2; addr = 8'h10; din = 32'hDEADBEEF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 clr_n = 1'b0;
      #1;
      n_checks++;
      if (dout2 !== 32'h0 || mfc2 !== 1'b0)
         $display("FAIL reset_midwait: got dout=%h mfc=%b want dout=0 mfc=0", dout2, mfc2);
      else n_pass++;
      mov = 1'b0; last2 = 32'h0; last0 = 32'h0;
      @(posedge clk); #1 clr_n = 1'b1;
      do_req(1'b1, 2'd2, 8'h10, 32'h0, 0, "rst_no_write");
   endtask

   task automatic test_word();
      do_req(1'b0, 2'd2, 8'h04, 32'h11223344, 0, "word_wr");
      do_req(1'b1, 2'd2, 8'h04, 32'h0, 0, "word_rd");
      do_req(1'b1, 2'd0, 8'h06, 32'h0, 0, "byte_rd");
   endtask

   task automatic test_subword();
      do_req(1'b0, 2'd2, 8'h08, 32'h0, 0, "sub_clear");
      do_req(1'b0, 2'd1, 8'h08, 32'h0000ABCD, 0, "half_wr");
      do_req(1'b0, 2'd0, 8'h0B, 32'h0000005A, 0, "byte_wr");
      do_req(1'b1, 2'd2, 8'h08, 32'h0, 0, "sub_word_rd");
      do_req(1'b1, 2'd1, 8'h0A, 32'h0, 0, "sub_half_rd");
   endtask

   task automatic test_align();
      do_req(1'b0, 2'd2, 8'h06, 32'hCAFEBABE, 0, "mis_word");
      do_req(1'b1, 2'd2, 8'h04, 32'h0, 0, "mis_ram_kept");
      do_req(1'b1, 2'd3, 8'h00, 32'h0, 0, "dt_reserved");
      do_req(1'b1, 2'd1, 8'h09, 32'h0, 0, "mis_half");
   endtask

   task automatic test_abort();
      do_req(1'b0, 2'd2, 8'h20, 32'h01020304, 0, "ab_pre");
      mov = 1'b1; rw = 1'b0; dt = 2'd2; addr = 8'h20; din = 32'hFFFFFFFF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      mov = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (mfc2 !== 1'b0) $display("FAIL abort_mfc%0d: got mfc=%b want 0", i, mfc2);
         else n_pass++;
      end
      do_req(1'b1, 2'd2, 8'h20, 32'h0, 0, "ab_ram_kept");
   endtask

   task automatic test_back_to_back();
      do_req(1'b1, 2'd2, 8'h04, 32'h0, 5, "b2b_hold");
      do_req(1'b1, 2'd0, 8'h07, 32'h0, 0, "b2b_next");
      sel0 = 1'b1;
      @(posedge clk); #1;
      do_req(1'b0, 2'd2, 8'h30, 32'hCAFEF00D, 2, "w0_wr");
      do_req(1'b1, 2'd2, 8'h30, 32'h0, 0, "w0_rd");
      do_req(1'b1, 2'd1, 8'h32, 32'h0, 0, "w0_half_rd");
      do_req(1'b1, 2'd2, 8'h35, 32'h0, 0, "w0_mis");
      sel0 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_word();
      test_subword();
      test_align();
      test_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
